sysctrl_master: RTL and testbench

//  Initiator end of the MCU byte-frame control protocol.

---
 rtl/sysctrl_master_pkg.sv | 32 +++
 rtl/sysctrl_master_pacer.sv | 37 +++
 rtl/sysctrl_master.sv | 185 ++++++++++++++++++
 tb/tb_sysctrl_master.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_master_pkg.sv
// Shared types for the sysctrl byte-frame initiator: command codes, FSM states
// and the default inter-strobe gap.
package sysctrl_master_pkg;

    typedef enum logic [7:0] {
        CmdStatus  = 8'd0,
        CmdLeds    = 8'd1,
        CmdColor   = 8'd2,
        CmdButtons = 8'd3,
        CmdConfig  = 8'd4,
        CmdInt     = 8'd5
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StGap,
        StData,
        StCap,
        StDone
    } state_e;

    // Which kind of frame is in flight: external request or one of the two poll frames.
    typedef enum logic [1:0] {
        PollNone,
        PollRead,
        PollAck
    } poll_e;

    localparam int unsigned DEFAULT_GAP = 2;

endpackage

// File: rtl/sysctrl_master_pacer.sv
// Strobe pacing: reloads a gap down-counter on every strobe and flags the last
// quiet cycle so the next byte may go out on the following cycle.
module sysctrl_master_pacer
    import sysctrl_master_pkg::*;
#(
    parameter int unsigned GAP = DEFAULT_GAP
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fire,
    output logic strobe,
    output logic slot
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = 8'(GAP);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = fire;
    assign slot   = (cnt_q == 8'd1);

endmodule

// File: rtl/sysctrl_master.sv
// Initiator for the MCU byte-frame control protocol: one request becomes a paced
// cmd + payload frame with per-byte response capture. Optional IRQ polling is
// enabled by defining SYSCTRL_MASTER_IRQ_POLL_EN.
module sysctrl_master
    import sysctrl_master_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned GAP     = DEFAULT_GAP
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_cmd,
    input  logic [3:0]             req_len,
    input  logic [8*MAX_LEN-1:0]   req_payload,
    output logic                   rsp_valid,
    output logic [3:0]             rsp_len,
    output logic [8*MAX_LEN-1:0]   rsp_data,
    output logic                   busy,
    output logic                   bus_strobe,
    output logic                   bus_start,
    output logic [7:0]             bus_dout,
    input  logic [7:0]             bus_din,
    input  logic                   irq_n,
    output logic [7:0]             irq_vec,
    output logic                   irq_vec_valid
);

    localparam logic [3:0] MaxLen = 4'(MAX_LEN);

    state_e     state_q, state_d;
    poll_e      poll_q, poll_d;
    logic [7:0] cmd_q, cmd_d;
    logic [3:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] pay_q [MAX_LEN];
    logic [7:0] pay_d [MAX_LEN];
    logic [7:0] rsp_q [MAX_LEN];
    logic [7:0] rsp_d [MAX_LEN];
    logic [7:0] vec_q, vec_d;
    logic [7:0] dout_q;
    logic [7:0] cur_byte;
    logic [3:0] len_clamped;
    logic       fire, slot, poll_req;

    sysctrl_master_pacer #(
        .GAP (GAP)
    ) u_pacer (
        .clk     (clk),
        .reset_n (reset_n),
        .fire    (fire),
        .strobe  (bus_strobe),
        .slot    (slot)
    );

    assign fire        = (state_q == StStart) || (state_q == StData);
    assign len_clamped = (req_len > MaxLen) ? MaxLen : req_len;

`ifdef SYSCTRL_MASTER_IRQ_POLL_EN
    assign poll_req      = !irq_n && !req_valid;
    assign irq_vec       = vec_q;
    assign irq_vec_valid = (state_q == StDone) && (poll_q == PollAck);
`else
    logic unused_poll;
    assign unused_poll   = ^{irq_n, vec_q};
    assign poll_req      = 1'b0;
    assign irq_vec       = 8'h00;
    assign irq_vec_valid = 1'b0;
`endif

    always_comb begin
        cur_byte = cmd_q;
        if (state_q == StData) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (idx_q == 4'(i)) cur_byte = pay_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pay_d   = pay_q;
        rsp_d   = rsp_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    len_d   = len_clamped;
                    idx_d   = 4'd0;
                    for (int i = 0; i < int'(MAX_LEN); i++) pay_d[i] = req_payload[8*i +: 8];
                    poll_d  = PollNone;
                    state_d = StStart;
                end else if (poll_req) begin
                    cmd_d    = CmdInt;
                    len_d    = 4'd1;
                    idx_d    = 4'd0;
                    pay_d[0] = 8'h00;
                    poll_d   = PollRead;
                    state_d  = StStart;
                end
            end
            StStart: state_d = StGap;
            StGap: begin
                if (slot) state_d = (idx_q < len_q) ? StData : StDone;
            end
            StData: state_d = StCap;
            StCap: begin
                // Responder registered data_out on the strobe edge; it is valid now.
                if (poll_q == PollNone) begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        if (idx_q == 4'(i)) rsp_d[i] = bus_din;
                    end
                end else if (poll_q == PollRead) begin
                    vec_d = bus_din;
                end
                idx_d = idx_q + 4'd1;
                if (slot) begin
                    state_d = (({1'b0, idx_q} + 5'd1) < {1'b0, len_q}) ? StData : StDone;
                end else begin
                    state_d = StGap;
                end
            end
            StDone: begin
                if (poll_q == PollRead) begin
                    // Chain straight into the acknowledge frame so req_ready never rises.
                    cmd_d    = CmdInt;
                    len_d    = 4'd1;
                    idx_d    = 4'd0;
                    pay_d[0] = vec_q;
                    poll_d   = PollAck;
                    state_d  = StStart;
                end else begin
                    poll_d  = PollNone;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            poll_q  <= PollNone;
            cmd_q   <= 8'h00;
            len_q   <= 4'd0;
            idx_q   <= 4'd0;
            vec_q   <= 8'h00;
            dout_q  <= 8'h00;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                pay_q[i] <= 8'h00;
                rsp_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            pay_q   <= pay_d;
            rsp_q   <= rsp_d;
            if (bus_strobe) dout_q <= cur_byte;
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) rsp_data[8*i +: 8] = rsp_q[i];
    end

    assign bus_dout  = bus_strobe ? cur_byte : dout_q;
    assign bus_start = (state_q == StStart);
    assign busy      = (state_q != StIdle);
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone) && (poll_q == PollNone);
    assign rsp_len   = len_q;

endmodule

// File: tb/tb_sysctrl_master.sv
// Directed bench for sysctrl_master against a small sysctrl responder model.
// Build with SYSCTRL_MASTER_IRQ_POLL_EN to exercise the IRQ poll frames.
module tb_sysctrl_master;

    localparam int ML = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [7:0]      req_cmd = 8'h00;
    logic [3:0]      req_len = 4'd0;
    logic [8*ML-1:0] req_payload = '0;
    logic            rsp_valid;
    logic [3:0]      rsp_len;
    logic [8*ML-1:0] rsp_data;
    logic            busy;
    logic            bus_strobe;
    logic            bus_start;
    logic [7:0]      bus_dout;
    logic [7:0]      bus_din;
    logic            irq_n;
    logic [7:0]      irq_vec;
    logic            irq_vec_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sysctrl_master #(
        .MAX_LEN (ML),
        .GAP     (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_len       (req_len),
        .req_payload   (req_payload),
        .rsp_valid     (rsp_valid),
        .rsp_len       (rsp_len),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .bus_strobe    (bus_strobe),
        .bus_start     (bus_start),
        .bus_dout      (bus_dout),
        .bus_din       (bus_din),
        .irq_n         (irq_n),
        .irq_vec       (irq_vec),
        .irq_vec_valid (irq_vec_valid)
    );

    // Responder model: status bytes for cmd 0, interrupt vector/ack for cmd 5,
    // payload ^ A5 for anything else; 0xEE after the cmd strobe.
    logic [7:0] r_cmd, r_dout, r_int_ack;
    logic       r_irq_n;
    logic       irq_set = 1'b0;
    localparam logic [7:0] IntVec = 8'h04;

    function automatic logic [7:0] status_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h5C;
            4'd1:    return 8'h42;
            4'd2:    return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    logic [3:0] r_idx;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd <= 8'h00; r_idx <= 4'd0; r_dout <= 8'h00; r_irq_n <= 1'b1; r_int_ack <= 8'h00;
        end else begin
            if (irq_set) r_irq_n <= 1'b0;
            if (bus_strobe) begin
                if (bus_start) begin
                    r_cmd <= bus_dout; r_idx <= 4'd0; r_dout <= 8'hEE;
                end else begin
                    r_idx <= r_idx + 4'd1;
                    if (r_cmd == 8'd0) begin
                        r_dout <= status_byte(r_idx);
                    end else if (r_cmd == 8'd5) begin
                        if (bus_dout == 8'h00) begin
                            r_dout <= IntVec;
                        end else begin
                            r_int_ack <= bus_dout; r_dout <= 8'h00; r_irq_n <= 1'b1;
                        end
                    end else begin
                        r_dout <= bus_dout ^ 8'hA5;
                    end
                end
            end
        end
    end
    assign bus_din = r_dout;
    assign irq_n   = r_irq_n;

    // Per-frame observation record filled by run_frame.
    int         sk [16];
    logic       ss [16];
    logic [7:0] sd [16];
    int         nstb, done_k, hold_err;
    logic [3:0] len_seen;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [3:0] len,
                             input logic [8*ML-1:0] pay);
        logic [7:0] last;
        nstb = 0; done_k = -1; hold_err = 0; last = 8'h00; len_seen = 4'hF;
        req_cmd = cmd; req_len = len; req_payload = pay; req_valid = 1'b1;
        tick();
        // Scramble operands after accept; the DUT must have latched them.
        req_valid = 1'b0; req_cmd = 8'hFF; req_len = 4'h7; req_payload = '1;
        for (int k = 1; k <= 200; k++) begin
            if (bus_strobe) begin
                if (nstb < 16) begin sk[nstb] = k; ss[nstb] = bus_start; sd[nstb] = bus_dout; end
                nstb++;
                last = bus_dout;
            end else if (nstb > 0 && bus_dout !== last) begin
                hold_err++;
            end
            if (rsp_valid) begin done_k = k; len_seen = rsp_len; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({req_ready, busy, bus_strobe, bus_start, rsp_valid, irq_vec_valid} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 100000",
                {req_ready, busy, bus_strobe, bus_start, rsp_valid, irq_vec_valid});
        end
        n_checks++;
        if ({bus_dout, rsp_len, irq_vec} !== 20'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus_dout, rsp_len, irq_vec});
        end
        n_checks++;
        if (rsp_data !== '0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got %b expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_status();
        run_frame(8'd0, 4'd3, '0);
        n_checks++;
        if (rsp_data[23:0] !== 24'h02425C) begin
            n_fail++; $display("FAIL status_data: got %h expected 02425c", rsp_data[23:0]);
        end
        n_checks++;
        if (len_seen !== 4'd3) begin
            n_fail++; $display("FAIL status_len: got %0d expected 3", len_seen);
        end
        tick();
    endtask

    task automatic test_pacing();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h02; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        run_frame(8'd2, 4'd3, 64'h0000_0000_0033_2211);
        n_checks++;
        if (nstb !== 4) begin n_fail++; $display("FAIL pacing_count: got %0d expected 4", nstb); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sk[i] !== 1 + 3 * i || ss[i] !== (i == 0) || sd[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL pacing_strobe%0d: got cyc %0d start %b dout %h expected cyc %0d start %b dout %h",
                    i, sk[i], ss[i], sd[i], 1 + 3 * i, (i == 0), exp_d[i]);
            end
        end
        n_checks++;
        if (done_k !== 13) begin n_fail++; $display("FAIL pacing_done: got %0d expected 13", done_k); end
        n_checks++;
        if (hold_err !== 0) begin n_fail++; $display("FAIL pacing_hold: got %0d expected 0", hold_err); end
        n_checks++;
        if (rsp_data[23:0] !== 24'h9687B4) begin
            n_fail++; $display("FAIL pacing_data: got %h expected 9687b4", rsp_data[23:0]);
        end
        tick();
    endtask

    task automatic test_len0();
        run_frame(8'd1, 4'd0, 64'h55);
        n_checks++;
        if (nstb !== 1 || ss[0] !== 1'b1 || sd[0] !== 8'h01) begin
            n_fail++; $display("FAIL len0_strobe: got n %0d start %b dout %h expected n 1 start 1 dout 01",
                nstb, ss[0], sd[0]);
        end
        n_checks++;
        if (done_k !== 4 || len_seen !== 4'd0) begin
            n_fail++; $display("FAIL len0_done: got cyc %0d len %0d expected cyc 4 len 0", done_k, len_seen);
        end
        n_checks++;
        if (rsp_data[7:0] !== 8'hB4) begin
            n_fail++; $display("FAIL len0_hold: got %h expected b4", rsp_data[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 10", {req_ready, busy});
        end
        run_frame(8'd2, 4'd1, 64'hC3);
        n_checks++;
        if (done_k !== 7 || rsp_data[7:0] !== 8'h66) begin
            n_fail++; $display("FAIL b2b_frame: got cyc %0d byte %h expected cyc 7 byte 66",
                done_k, rsp_data[7:0]);
        end
        tick();
    endtask

    task automatic test_clamp();
        logic [8*ML-1:0] pay;
        logic [8*ML-1:0] exp_rsp;
        for (int i = 0; i < ML; i++) begin
            pay[8*i +: 8]     = 8'h10 + 8'(i);
            exp_rsp[8*i +: 8] = (8'h10 + 8'(i)) ^ 8'hA5;
        end
        run_frame(8'd1, 4'd15, pay);
        n_checks++;
        if (nstb !== 9) begin n_fail++; $display("FAIL clamp_strobes: got %0d expected 9", nstb); end
        n_checks++;
        if (len_seen !== 4'd8 || done_k !== 28) begin
            n_fail++; $display("FAIL clamp_len: got len %0d cyc %0d expected len 8 cyc 28", len_seen, done_k);
        end
        n_checks++;
        if (rsp_data !== exp_rsp) begin
            n_fail++; $display("FAIL clamp_data: got %h expected %h", rsp_data, exp_rsp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int extra, rv;
        extra = 0; rv = 0;
        req_cmd = 8'd1; req_len = 4'd4; req_payload = 64'h44_33_22_11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        // Cycle 10 carries payload byte 2.
        n_checks++;
        if (bus_strobe !== 1'b1 || bus_dout !== 8'h33) begin
            n_fail++; $display("FAIL mid_pre: got strobe %b dout %h expected 1 33", bus_strobe, bus_dout);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_strobe !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: got strobe %b busy %b expected 0 0", bus_strobe, busy);
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_strobe) extra++;
            if (rsp_valid) rv++;
        end
        n_checks++;
        if (extra !== 0 || rv !== 0) begin
            n_fail++; $display("FAIL mid_quiet: got strobes %0d rsp %0d expected 0 0", extra, rv);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_irq();
`ifdef SYSCTRL_MASTER_IRQ_POLL_EN
        int pulses, rv, rdy_err;
        logic [7:0] vec_seen;
        pulses = 0; rv = 0; rdy_err = 0; nstb = 0; vec_seen = 8'h00;
        irq_set = 1'b1;
        tick();
        irq_set = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus_strobe) begin
                if (nstb < 16) begin ss[nstb] = bus_start; sd[nstb] = bus_dout; end
                nstb++;
            end
            if (rsp_valid) rv++;
            if (nstb > 0 && pulses == 0 && req_ready) rdy_err++;
            if (irq_vec_valid) begin pulses++; vec_seen = irq_vec; end
            tick();
        end
        n_checks++;
        if (nstb !== 4) begin n_fail++; $display("FAIL irq_strobes: got %0d expected 4", nstb); end
        n_checks++;
        if ({ss[0], sd[0], ss[1], sd[1], ss[2], sd[2], ss[3], sd[3]} !== {1'b1, 8'h05, 1'b0, 8'h00,
                                                                         1'b1, 8'h05, 1'b0, 8'h04}) begin
            n_fail++; $display("FAIL irq_frames: got %b/%h %b/%h %b/%h %b/%h expected 1/05 0/00 1/05 0/04",
                ss[0], sd[0], ss[1], sd[1], ss[2], sd[2], ss[3], sd[3]);
        end
        n_checks++;
        if (pulses !== 1 || vec_seen !== 8'h04) begin
            n_fail++; $display("FAIL irq_vec: got %0d pulses vec %h expected 1 04", pulses, vec_seen);
        end
        n_checks++;
        if (rv !== 0 || rdy_err !== 0) begin
            n_fail++; $display("FAIL irq_side: got rsp %0d ready %0d expected 0 0", rv, rdy_err);
        end
        n_checks++;
        if (r_int_ack !== 8'h04 || irq_n !== 1'b1) begin
            n_fail++; $display("FAIL irq_ack: got ack %h irq_n %b expected 04 1", r_int_ack, irq_n);
        end
`else
        int act;
        act = 0;
        irq_set = 1'b1;
        tick();
        irq_set = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus_strobe || busy || irq_vec_valid || irq_vec !== 8'h00) act++;
            tick();
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL irq_ignored: got %0d active cycles expected 0", act); end
        n_checks++;
        if (irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_line: got %b expected 0", irq_n); end
`endif
    endtask

    initial begin
        test_reset();
        test_status();
        test_pacing();
        test_len0();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
